// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin owner selection for a shared 3:8 one-hot
// decoder. Holds a grant until release or timeout, and inserts one dead
// cycle between owners (break-before-make).
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] done,
    output logic [2:0] grant_idx,
    output logic       grant_en,
    output logic [7:0] grant_onehot,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam bit                TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_rr_ptr;
    logic [2:0]        w_rr_ptr_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [2:0]        r_grant_idx;
    logic [2:0]        w_grant_idx_nxt;
    logic              r_grant_en;
    logic              w_grant_en_nxt;
    logic [7:0]        r_grant_onehot;
    logic [7:0]        w_grant_onehot_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic              w_found;
    logic [2:0]        w_winner;
    logic              w_release;

    // Rotating priority search: first requester at or after r_rr_ptr, with wrap.
    always_comb begin
        logic [2:0] cand;
        w_found  = 1'b0;
        w_winner = '0;
        cand     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = r_rr_ptr + 3'(i);
            if (!w_found && req[cand]) begin
                w_found  = 1'b1;
                w_winner = cand;
            end
        end
    end

    // Owner gives up the resource by pulsing its done bit or dropping its request.
    always_comb begin
        w_release = done[r_grant_idx] | ~req[r_grant_idx];
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        w_state_nxt        = r_state;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_grant_idx_nxt    = r_grant_idx;
        w_grant_en_nxt     = 1'b0;
        w_grant_onehot_nxt = '0;
        w_busy_nxt         = 1'b0;
        w_timeout_nxt      = 1'b0;

        case (r_state)
            S_IDLE, S_GAP: begin
                if (w_found) begin
                    w_state_nxt        = S_GRANT;
                    w_rr_ptr_nxt       = w_winner + 3'd1;
                    w_hold_cnt_nxt     = '0;
                    w_grant_idx_nxt    = w_winner;
                    w_grant_en_nxt     = 1'b1;
                    w_grant_onehot_nxt = 8'b0000_0001 << w_winner;
                    w_busy_nxt         = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    // A release wins over a coincident timeout: no timeout pulse.
                    w_state_nxt = S_GAP;
                    w_busy_nxt  = 1'b1;
                end else if (TIMEOUT_EN && (r_hold_cnt == HOLD_LAST)) begin
                    w_state_nxt   = S_GAP;
                    w_busy_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt     = r_hold_cnt + 1'b1;
                    w_grant_en_nxt     = 1'b1;
                    w_grant_onehot_nxt = r_grant_onehot;
                    w_busy_nxt         = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything, including a live grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_hold_cnt     <= '0;
            r_grant_idx    <= '0;
            r_grant_en     <= 1'b0;
            r_grant_onehot <= '0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_grant_idx    <= w_grant_idx_nxt;
            r_grant_en     <= w_grant_en_nxt;
            r_grant_onehot <= w_grant_onehot_nxt;
            r_busy         <= w_busy_nxt;
            r_timeout      <= w_timeout_nxt;
        end
    end

    assign grant_idx    = r_grant_idx;
    assign grant_en     = r_grant_en;
    assign grant_onehot = r_grant_onehot;
    assign busy         = r_busy;
    assign timeout      = r_timeout;

endmodule
